// File: rtl/branch_predictor_pkg.sv
// Shared fetch/predictor control types: next-PC select codes, counter states, BTB entry layout.
package branch_predictor_pkg;

    localparam int BP_IDX_W = 6;
    localparam int BP_TAG_W = 24;

    typedef enum logic [1:0] {
        PC_SRC_SEQ_F    = 2'b00,
        PC_SRC_PRED_F   = 2'b01,
        PC_SRC_SEQ_E    = 2'b10,
        PC_SRC_TARGET_E = 2'b11
    } pc_src_e;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [29:0]         target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolve signals between the pipeline (master) and predictor (slave).
interface branch_predictor_if #(
    parameter int IDX_W = branch_predictor_pkg::BP_IDX_W
) ();
    import branch_predictor_pkg::*;

    logic [31:0]      pc_fi_i;
    logic             pred_taken_fi_o;
    logic [31:0]      pred_pc_target_fi_o;
    logic [IDX_W-1:0] pred_idx_fi_o;

    logic             branch_ex_i;
    logic             jump_ex_i;
    logic             taken_ex_i;
    logic [31:0]      pc_ex_i;
    logic [31:0]      pc_target_ex_i;
    logic             pred_taken_ex_i;
    logic [31:0]      pred_pc_target_ex_i;
    logic [IDX_W-1:0] pred_idx_ex_i;

    logic             mispredict_ex_o;
    pc_src_e          pc_src_o;

    modport master (
        output pc_fi_i, branch_ex_i, jump_ex_i, taken_ex_i, pc_ex_i, pc_target_ex_i,
               pred_taken_ex_i, pred_pc_target_ex_i, pred_idx_ex_i,
        input  pred_taken_fi_o, pred_pc_target_fi_o, pred_idx_fi_o, mispredict_ex_o, pc_src_o
    );

    modport slave (
        input  pc_fi_i, branch_ex_i, jump_ex_i, taken_ex_i, pc_ex_i, pc_target_ex_i,
               pred_taken_ex_i, pred_pc_target_ex_i, pred_idx_ex_i,
        output pred_taken_fi_o, pred_pc_target_fi_o, pred_idx_fi_o, mispredict_ex_o, pc_src_o
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter step: increment on taken, decrement on not-taken, clamp at 00/11.
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'b01;
        end else begin
            if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with EX-stage resolve, redirect and training.
// Define GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t       btb_q [ENTRIES];
    btb_entry_t       btb_d [ENTRIES];
    logic [1:0]       cnt_q [ENTRIES];
    logic [1:0]       cnt_d [ENTRIES];

    logic [IDX_W-1:0] bidx;
    logic [IDX_W-1:0] uidx;
    logic [IDX_W-1:0] pidx;
    logic [IDX_W-1:0] cidx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             f_hit;
    logic             ex_hit;
    logic             ex_valid;
    logic             ctl_taken;
    logic [1:0]       cnt_upd;

    assign bidx   = bp.pc_fi_i[IDX_W+1:2];
    assign uidx   = bp.pc_ex_i[IDX_W+1:2];
    assign f_tag  = bp.pc_fi_i[IDX_W+2+TAG_W-1:IDX_W+2];
    assign ex_tag = bp.pc_ex_i[IDX_W+2+TAG_W-1:IDX_W+2];

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    assign pidx = bidx ^ ghr_q;
    assign cidx = bp.pred_idx_ex_i;

    // Only conditional branches shift history; jumps leave it alone.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.branch_ex_i) ghr_d = {ghr_q[IDX_W-2:0], bp.taken_ex_i};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ghr_q <= '0;
        else            ghr_q <= ghr_d;
    end
`else
    logic unused_pred_idx;

    assign pidx            = bidx;
    assign cidx            = uidx;
    assign unused_pred_idx = ^bp.pred_idx_ex_i;
`endif

    logic unused_low_bits;
    assign unused_low_bits = ^{bp.pc_fi_i[1:0], bp.pc_ex_i[1:0], bp.pc_target_ex_i[1:0]};

    assign f_hit  = btb_q[bidx].valid && (btb_q[bidx].tag == f_tag);
    assign ex_hit = btb_q[uidx].valid && (btb_q[uidx].tag == ex_tag);

    assign bp.pred_idx_fi_o       = pidx;
    assign bp.pred_taken_fi_o     = f_hit & cnt_q[pidx][1];
    assign bp.pred_pc_target_fi_o = f_hit ? {btb_q[bidx].target, 2'b00} : 32'h0;

    assign ex_valid  = bp.branch_ex_i | bp.jump_ex_i;
    assign ctl_taken = bp.jump_ex_i | (bp.branch_ex_i & bp.taken_ex_i);
    assign bp.mispredict_ex_o = ex_valid &
        ((ctl_taken != bp.pred_taken_ex_i) ||
         (ctl_taken && (bp.pc_target_ex_i != bp.pred_pc_target_ex_i)));

    always_comb begin
        bp.pc_src_o = PC_SRC_SEQ_F;
        if (bp.mispredict_ex_o)     bp.pc_src_o = ctl_taken ? PC_SRC_TARGET_E : PC_SRC_SEQ_E;
        else if (bp.pred_taken_fi_o) bp.pc_src_o = PC_SRC_PRED_F;
    end

    branch_predictor_sat_counter2 u_sat (
        .cnt_i (cnt_q[cidx]),
        .inc_i (bp.taken_ex_i),
        .cnt_o (cnt_upd)
    );

    // A taken hit rewrites the same tag, so hit and allocate share one write.
    always_comb begin
        btb_d = btb_q;
        cnt_d = cnt_q;
        if (ex_valid && ctl_taken) begin
            btb_d[uidx] = '{valid: 1'b1, tag: ex_tag, target: bp.pc_target_ex_i[31:2]};
        end
        if (bp.jump_ex_i) begin
            cnt_d[cidx] = CNT_ST;
        end else if (bp.branch_ex_i) begin
            if (ex_hit)               cnt_d[cidx] = cnt_upd;
            else if (bp.taken_ex_i)   cnt_d[cidx] = CNT_WT;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            btb_q <= btb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: step tables drive fetch/EX, expected outputs are queued and compared.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IDX_W = BP_IDX_W;
    localparam logic [1:0] SF = PC_SRC_SEQ_F;
    localparam logic [1:0] PF = PC_SRC_PRED_F;
    localparam logic [1:0] SE = PC_SRC_SEQ_E;
    localparam logic [1:0] TE = PC_SRC_TARGET_E;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    branch_predictor_if #(.IDX_W(IDX_W)) bp_if ();

    branch_predictor #(.IDX_W(IDX_W), .TAG_W(BP_TAG_W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bp        (bp_if.slave)
    );

    typedef struct {
        string       name;
        bit          rst;
        bit          br, jp, tk;
        logic [31:0] pc_ex, tgt_ex;
        bit          pt_ex;
        logic [31:0] ptgt_ex;
        logic [5:0]  pidx_ex;
        logic [31:0] pc_fi;
        logic [41:0] exp;
    } step_t;

    typedef struct {
        string       name;
        logic [41:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic step_t mk(string name, bit rst, bit br, bit jp, bit tk,
                                 logic [31:0] pc_ex, logic [31:0] tgt_ex, bit pt_ex,
                                 logic [31:0] ptgt_ex, logic [5:0] pidx_ex, logic [31:0] pc_fi,
                                 logic [5:0] e_idx, bit e_pt, logic [31:0] e_tgt,
                                 logic [1:0] e_src, bit e_mis);
        step_t s;
        s.name = name; s.rst = rst; s.br = br; s.jp = jp; s.tk = tk;
        s.pc_ex = pc_ex; s.tgt_ex = tgt_ex; s.pt_ex = pt_ex; s.ptgt_ex = ptgt_ex;
        s.pidx_ex = pidx_ex; s.pc_fi = pc_fi;
        s.exp = {e_idx, e_pt, e_tgt, e_src, e_mis};
        return s;
    endfunction

    function automatic logic [41:0] observed();
        return {bp_if.pred_idx_fi_o, bp_if.pred_taken_fi_o, bp_if.pred_pc_target_fi_o,
                bp_if.pc_src_o, bp_if.mispredict_ex_o};
    endfunction

    task automatic drive(input step_t s);
        reset_n_i                 = s.rst;
        bp_if.pc_fi_i             = s.pc_fi;
        bp_if.branch_ex_i         = s.br;
        bp_if.jump_ex_i           = s.jp;
        bp_if.taken_ex_i          = s.tk;
        bp_if.pc_ex_i             = s.pc_ex;
        bp_if.pc_target_ex_i      = s.tgt_ex;
        bp_if.pred_taken_ex_i     = s.pt_ex;
        bp_if.pred_pc_target_ex_i = s.ptgt_ex;
        bp_if.pred_idx_ex_i       = s.pidx_ex;
    endtask

    task automatic test_reset();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("rst_idle",    0, 0,0,0, 'h100,'h000,0,'h000,0, 'h100, 'h00,0,'h000,SF,0));
        s.push_back(mk("rst_ex_mis",  0, 1,0,1, 'h100,'h200,0,'h000,0, 'h100, 'h00,0,'h000,TE,1));
        s.push_back(mk("rst_release", 1, 0,0,0, 'h000,'h000,0,'h000,0, 'h100, 'h00,0,'h000,SF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_allocate_saturate();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("alloc_mis",   1, 1,0,1, 'h100,'h200,0,'h000,0, 'h100, 'h00,0,'h000,TE,1));
        s.push_back(mk("alloc_hit",   1, 0,0,0, 'h000,'h000,0,'h000,0, 'h100, 'h00,1,'h200,PF,0));
        s.push_back(mk("nt1_mis",     1, 1,0,0, 'h100,'h104,1,'h200,0, 'h100, 'h00,1,'h200,SE,1));
        s.push_back(mk("nt2_wnt",     1, 1,0,0, 'h100,'h104,0,'h000,0, 'h100, 'h00,0,'h200,SF,0));
        s.push_back(mk("nt3_snt",     1, 1,0,0, 'h100,'h104,0,'h000,0, 'h100, 'h00,0,'h200,SF,0));
        s.push_back(mk("tk_from_snt", 1, 1,0,1, 'h100,'h200,0,'h000,0, 'h100, 'h00,0,'h200,TE,1));
        s.push_back(mk("tk_from_wnt", 1, 1,0,1, 'h100,'h200,0,'h000,0, 'h100, 'h00,0,'h200,TE,1));
        s.push_back(mk("wt_predict",  1, 0,0,0, 'h000,'h000,0,'h000,0, 'h100, 'h00,1,'h200,PF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_target_and_jump();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("tgt_mis",     1, 1,0,1, 'h100,'h300,1,'h200,0, 'h100, 'h00,1,'h200,TE,1));
        s.push_back(mk("tgt_correct", 1, 1,0,1, 'h100,'h300,1,'h300,0, 'h100, 'h00,1,'h300,PF,0));
        s.push_back(mk("tgt_new",     1, 0,0,0, 'h000,'h000,0,'h000,0, 'h100, 'h00,1,'h300,PF,0));
        s.push_back(mk("jmp_alloc",   1, 0,1,0, 'h044,'h080,0,'h000,0, 'h044, 'h11,0,'h000,TE,1));
        s.push_back(mk("jmp_then_nt", 1, 1,0,0, 'h044,'h048,1,'h080,0, 'h044, 'h11,1,'h080,SE,1));
        s.push_back(mk("jmp_cnt_wt",  1, 0,0,0, 'h000,'h000,0,'h000,0, 'h044, 'h11,1,'h080,PF,0));
        s.push_back(mk("jmp_correct", 1, 0,1,0, 'h044,'h080,1,'h080,0, 'h044, 'h11,1,'h080,PF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_alias();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("alias_alloc",  1, 1,0,1, 'h200,'h500,0,'h000,0, 'h200, 'h00,0,'h000,TE,1));
        s.push_back(mk("alias_evict",  1, 0,0,0, 'h000,'h000,0,'h000,0, 'h100, 'h00,0,'h000,SF,0));
        s.push_back(mk("alias_new",    1, 0,0,0, 'h000,'h000,0,'h000,0, 'h200, 'h00,1,'h500,PF,0));
        s.push_back(mk("miss_nt",      1, 1,0,0, 'h300,'h304,0,'h000,0, 'h200, 'h00,1,'h500,PF,0));
        s.push_back(mk("miss_nt_keep", 1, 0,0,0, 'h000,'h000,0,'h000,0, 'h200, 'h00,1,'h500,PF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("same_cyc_old", 1, 1,0,1, 'h0F0,'h010,0,'h000,0, 'h0F0, 'h3C,0,'h000,TE,1));
        s.push_back(mk("same_cyc_new", 1, 0,0,0, 'h000,'h000,0,'h000,0, 'h0F0, 'h3C,1,'h010,PF,0));
        s.push_back(mk("b2b_nt1",      1, 1,0,0, 'h0F0,'h0F4,1,'h010,0, 'h0F0, 'h3C,1,'h010,SE,1));
        s.push_back(mk("b2b_nt2",      1, 1,0,0, 'h0F0,'h0F4,0,'h000,0, 'h0F0, 'h3C,0,'h010,SF,0));
        s.push_back(mk("b2b_idle",     1, 0,0,0, 'h000,'h000,0,'h000,0, 'h0F0, 'h3C,0,'h010,SF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_gshare();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("gs_alloc",     1, 1,0,1, 'h100,'h200,0,'h000,'h00, 'h100, 'h00,0,'h000,TE,1));
        s.push_back(mk("gs_ghr1_nt",   1, 1,0,0, 'h100,'h104,0,'h000,'h01, 'h100, 'h01,0,'h200,SF,0));
        s.push_back(mk("gs_ghr2_idx",  1, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h100, 'h02,0,'h200,SF,0));
        s.push_back(mk("gs_jump",      1, 0,1,0, 'h080,'h0C0,0,'h000,'h22, 'h104, 'h03,0,'h000,TE,1));
        s.push_back(mk("gs_jump_noshf",1, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h080, 'h22,1,'h0C0,PF,0));
        s.push_back(mk("gs_tk",        1, 1,0,1, 'h100,'h200,0,'h000,'h02, 'h100, 'h02,0,'h200,TE,1));
        s.push_back(mk("gs_ghr5_idx",  1, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h100, 'h05,0,'h200,SF,0));
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        sb_t   e;
        s.push_back(mk("mid_cleared", 0, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h100, 'h00,0,'h000,SF,0));
        s.push_back(mk("mid_ex_only", 0, 1,0,0, 'h080,'h084,1,'h0C0,'h00, 'h100, 'h00,0,'h000,SE,1));
        s.push_back(mk("mid_first",   1, 1,0,1, 'h080,'h0C0,0,'h000,'h20, 'h080, 'h20,0,'h000,TE,1));
`ifdef GSHARE_EN
        s.push_back(mk("mid_trained", 1, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h080, 'h21,0,'h0C0,SF,0));
`else
        s.push_back(mk("mid_trained", 1, 0,0,0, 'h000,'h000,0,'h000,'h00, 'h080, 'h20,1,'h0C0,PF,0));
`endif
        foreach (s[i]) begin
            @(negedge clk_i);
            drive(s[i]);
            sb_q.push_back('{s[i].name, s[i].exp});
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e.exp) begin
                n_errors++;
                $display("FAIL %s: observed=%h expected=%h", e.name, observed(), e.exp);
            end
        end
    endtask

    initial begin
        drive(mk("init", 0, 0,0,0, 0,0,0,0,0, 'h100, 0,0,0,SF,0));
        test_reset();
`ifdef GSHARE_EN
        test_gshare();
`else
        test_allocate_saturate();
        test_target_and_jump();
        test_alias();
        test_back_to_back();
`endif
        test_reset_mid();
        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
